// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_sequencer_pkg                                                |
// | Brief    : Shared encodings for the PC sequencer and the branch condition  |
// |            decoder: control class, branch funct3, ALU flag bits, states.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package pc_sequencer_pkg;

    // Execute-stage control class
    localparam logic [1:0] PCS_NONE = 2'b00;
    localparam logic [1:0] PCS_BR   = 2'b01;
    localparam logic [1:0] PCS_JAL  = 2'b10;
    localparam logic [1:0] PCS_JALR = 2'b11;

    // Branch condition codes (funct3)
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // Bit positions inside the {eq, lt, ltu} ALU flag vector
    localparam int FLAG_EQ  = 2;
    localparam int FLAG_LT  = 1;
    localparam int FLAG_LTU = 0;

    // Fetch sequencer states
    typedef logic [1:0] state_t;
    localparam state_t RUN     = 2'd0;
    localparam state_t MEMWAIT = 2'd1;
    localparam state_t PENDING = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_branch_cond.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : branch_cond                                                     |
// | Brief    : Combinational branch condition evaluation from funct3 and the   |
// |            ALU comparison flags. Shared with the hazard unit.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module branch_cond (
    input  logic [2:0] i_funct3,
    input  logic [2:0] i_alu_flags,
    output logic       o_cond
);
    import pc_sequencer_pkg::*;

    // Select and optionally invert the comparison flag named by funct3
    always_comb begin
        o_cond = 1'b0;
        case (i_funct3)
            BEQ:     o_cond =  i_alu_flags[FLAG_EQ];
            BNE:     o_cond = ~i_alu_flags[FLAG_EQ];
            BLT:     o_cond =  i_alu_flags[FLAG_LT];
            BGE:     o_cond = ~i_alu_flags[FLAG_LT];
            BLTU:    o_cond =  i_alu_flags[FLAG_LTU];
            BGEU:    o_cond = ~i_alu_flags[FLAG_LTU];
            default: o_cond = 1'b0;   // 010/011 are not branch encodings
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_sequencer                                                    |
// | Brief    : Program counter owner: resolves Execute-stage branches/jumps,   |
// |            sequences fetch against a ready-gated instruction memory,       |
// |            flushes Decode/Execute on redirect, traps misaligned targets.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pc_sequencer #(
    parameter int                 PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(32'h0040_0000),
    parameter int                 CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic [1:0]           PCS,
    input  logic [2:0]           Funct3,
    input  logic [2:0]           ALUFlags,
    input  logic                 ExValid,
    input  logic [PC_WIDTH-1:0]  BranchTarget,
    input  logic [PC_WIDTH-1:0]  JalrTarget,
    input  logic                 Stall,
    input  logic                 IMemReady,
    output logic [PC_WIDTH-1:0]  PC,
    output logic [PC_WIDTH-1:0]  PC_Plus4,
    output logic                 FetchValid,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 Taken,
    output logic                 Fault,
    output logic [CNT_WIDTH-1:0] TakenCount
);
    import pc_sequencer_pkg::*;

    logic [PC_WIDTH-1:0]  r_pc;
    logic [PC_WIDTH-1:0]  r_pend;
    state_t               r_state;
    logic                 r_fault;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic [PC_WIDTH-1:0]  w_pc_nxt;
    logic [PC_WIDTH-1:0]  w_pend_nxt;
    state_t               w_state_nxt;
    logic [PC_WIDTH-1:0]  w_pc_plus4;
    logic [PC_WIDTH-1:0]  w_target;
    logic                 w_cond;
    logic                 w_rq;
    logic                 w_mis;
    logic                 w_taken;
    logic                 w_unused_jalr0;

    branch_cond u_branch_cond (
        .i_funct3    (Funct3),
        .i_alu_flags (ALUFlags),
        .o_cond      (w_cond)
    );

    // jalr clears bit 0 of its target, so that bit never reaches the PC
    assign w_unused_jalr0 = JalrTarget[0];

    assign w_pc_plus4 = r_pc + PC_WIDTH'(4);
    assign w_rq       = ExValid & ((PCS == PCS_JAL) | (PCS == PCS_JALR) |
                                   ((PCS == PCS_BR) & w_cond));
    assign w_target   = (PCS == PCS_JALR) ? {JalrTarget[PC_WIDTH-1:1], 1'b0}
                                          : BranchTarget;
    assign w_mis      = w_rq & w_target[1];
    // Gated by reset so no flush escapes while the core is held in reset
    assign w_taken    = RESETn & w_rq & ~w_mis & ~r_fault;

    assign PC         = r_pc;
    assign PC_Plus4   = w_pc_plus4;
    assign Taken      = w_taken;
    assign FlushD     = w_taken;
    assign FlushE     = w_taken;
    assign Fault      = r_fault;
    assign TakenCount = r_cnt;
    assign FetchValid = (r_state == RUN) & IMemReady & ~r_fault & ~w_taken;

    // Next PC / state / pending target; redirect outranks memory wait and stall
    always_comb begin
        w_pc_nxt    = r_pc;
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        if (!r_fault && !w_mis) begin
            case (r_state)
                RUN: begin
                    if (w_taken) begin
                        if (IMemReady) begin
                            w_pc_nxt = w_target;
                        end else begin
                            w_pend_nxt  = w_target;
                            w_state_nxt = PENDING;
                        end
                    end else if (!IMemReady) begin
                        w_state_nxt = MEMWAIT;
                    end else if (!Stall) begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end
                MEMWAIT: begin
                    if (w_taken) begin
                        w_pend_nxt = w_target;
                        if (IMemReady) begin
                            w_pc_nxt    = w_target;
                            w_state_nxt = RUN;
                        end else begin
                            w_state_nxt = PENDING;
                        end
                    end else if (IMemReady) begin
                        w_state_nxt = RUN;
                        if (!Stall) w_pc_nxt = w_pc_plus4;
                    end
                end
                PENDING: begin
                    // A younger redirect replaces the one still waiting
                    if (w_taken) begin
                        w_pend_nxt = w_target;
                        if (IMemReady) begin
                            w_pc_nxt    = w_target;
                            w_state_nxt = RUN;
                        end
                    end else if (IMemReady) begin
                        w_pc_nxt    = r_pend;
                        w_state_nxt = RUN;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    // State, PC, sticky fault and saturating redirect counter registers
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_pc    <= RESET_PC;
            r_pend  <= '0;
            r_state <= RUN;
            r_fault <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_pend  <= w_pend_nxt;
            r_state <= w_state_nxt;
            r_fault <= r_fault | w_mis;
            if (w_taken && (r_cnt != '1)) r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire
